ga_input_vec_builder: RTL and testbench

GA_INPUT_VEC_BUILDER -- requirements
Module: ga_input_vec_builder

---
 rtl/ga_input_vec_builder.sv | 149 ++++++++++++++
 tb/tb_ga_input_vec_builder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ga_input_vec_builder.sv
// rtl/ga_input_vec_builder.sv - delay-line tap vector builder feeding the GA main FSM
//
// Purpose: shifts incoming samples into an M_MAX-tap delay line.  Once the
// first m_eff taps are filled, it emits one vector-valid pulse per accepted
// sample. The downstream FSM paces the block with i_ga_ready.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   cnfg_m            requested filter length; latched when the block leaves IDLE
//   i_ga_enable       level enable; low returns the block to IDLE and clears taps
//   i_x_valid/i_x_data, o_x_ready   upstream sample handshake
//   i_ga_ready        downstream can take a vector
//   o_valid_pls       one-cycle vector-valid pulse
//   o_v_vec_flat_n    taps, tap k at bits [(k+1)*DATA_W-1 : k*DATA_W]; taps >= m_eff read 0
//   o_fill_cnt        number of valid taps
//   o_vec_cnt         emitted-vector counter (wraps)
module ga_input_vec_builder #(
    parameter int DATA_W      = 6,
    parameter int M_MAX       = 32,
    parameter int M_MAX_W     = $clog2(M_MAX + 1),
    parameter int CHROM_MAX_W = DATA_W * M_MAX
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [M_MAX_W-1:0]     cnfg_m,
    input  logic                   i_ga_enable,
    input  logic                   i_x_valid,
    input  logic [DATA_W-1:0]      i_x_data,
    output logic                   o_x_ready,
    input  logic                   i_ga_ready,
    output logic                   o_valid_pls,
    output logic [CHROM_MAX_W-1:0] o_v_vec_flat_n,
    output logic [M_MAX_W-1:0]     o_fill_cnt,
    output logic [15:0]            o_vec_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [M_MAX_W-1:0] M_ONE     = M_MAX_W'(1);
    localparam logic [M_MAX_W-1:0] M_MAX_VAL = M_MAX_W'(M_MAX);

    logic [1:0]             r_state;
    logic [CHROM_MAX_W-1:0] r_taps;
    logic [M_MAX_W-1:0]     r_m_eff;
    logic [M_MAX_W-1:0]     r_fill_cnt;
    logic [15:0]            r_vec_cnt;
    logic                   r_valid_pls;
    // PEND waits one cycle before sampling i_ga_ready.  This gives a minimum
    // latency of two cycles from the completing transfer to the pulse.
    logic                   r_armed;

    logic                   w_xfer;
    logic [M_MAX_W-1:0]     w_m_clamped;
    logic [M_MAX_W-1:0]     w_fill_inc;
    logic [CHROM_MAX_W-1:0] w_vec;

    // Ready is gated by the enable so that a sample is never acknowledged on
    // the same edge that discards the delay line.
    assign o_x_ready = i_ga_enable & ((r_state == S_FILL) | (r_state == S_RUN));
    assign w_xfer    = i_x_valid & o_x_ready;
    assign w_fill_inc = r_fill_cnt + M_ONE;

    always_comb begin
        w_m_clamped = cnfg_m;
        if (cnfg_m == '0) begin
            w_m_clamped = M_ONE;
        end else if (cnfg_m > M_MAX_VAL) begin
            w_m_clamped = M_MAX_VAL;
        end
    end

    // Taps beyond m_eff still hold shifted history.  They are masked here,
    // not cleared in the delay line.
    always_comb begin
        w_vec = '0;
        for (int k = 0; k < M_MAX; k++) begin
            if (k < int'(r_m_eff)) begin
                w_vec[k*DATA_W +: DATA_W] = r_taps[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_taps      <= '0;
            r_m_eff     <= '0;
            r_fill_cnt  <= '0;
            r_vec_cnt   <= '0;
            r_valid_pls <= 1'b0;
            r_armed     <= 1'b0;
        end else if (!i_ga_enable) begin
            // Disable overrides everything, including a pulse due on this edge.
            r_state     <= S_IDLE;
            r_taps      <= '0;
            r_fill_cnt  <= '0;
            r_valid_pls <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_valid_pls <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_m_eff    <= w_m_clamped;
                    r_fill_cnt <= '0;
                    r_armed    <= 1'b0;
                    r_state    <= S_FILL;
                end
                S_FILL: begin
                    if (w_xfer) begin
                        r_taps     <= {r_taps[CHROM_MAX_W-DATA_W-1:0], i_x_data};
                        r_fill_cnt <= w_fill_inc;
                        if (w_fill_inc == r_m_eff) begin
                            r_armed <= 1'b0;
                            r_state <= S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (!r_armed) begin
                        r_armed <= 1'b1;
                    end else if (i_ga_ready) begin
                        r_valid_pls <= 1'b1;
                        r_vec_cnt   <= r_vec_cnt + 16'd1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_taps  <= {r_taps[CHROM_MAX_W-DATA_W-1:0], i_x_data};
                        r_armed <= 1'b0;
                        r_state <= S_PEND;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_valid_pls    = r_valid_pls;
    assign o_v_vec_flat_n = w_vec;
    assign o_fill_cnt     = r_fill_cnt;
    assign o_vec_cnt      = r_vec_cnt;

endmodule

// File: tb/tb_ga_input_vec_builder.sv
// tb/tb_ga_input_vec_builder.sv - directed self-checking bench for ga_input_vec_builder
module tb_ga_input_vec_builder;

    localparam int DATA_W      = 6;
    localparam int M_MAX       = 32;
    localparam int M_MAX_W     = 6;
    localparam int CHROM_MAX_W = DATA_W * M_MAX;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [M_MAX_W-1:0]     cnfg_m = '0;
    logic                   i_ga_enable = 1'b0;
    logic                   i_x_valid = 1'b0;
    logic [DATA_W-1:0]      i_x_data = '0;
    logic                   o_x_ready;
    logic                   i_ga_ready = 1'b0;
    logic                   o_valid_pls;
    logic [CHROM_MAX_W-1:0] o_v_vec_flat_n;
    logic [M_MAX_W-1:0]     o_fill_cnt;
    logic [15:0]            o_vec_cnt;

    ga_input_vec_builder #(
        .DATA_W(DATA_W), .M_MAX(M_MAX), .M_MAX_W(M_MAX_W), .CHROM_MAX_W(CHROM_MAX_W)
    ) dut (
        .clk(clk), .rstn(rstn), .cnfg_m(cnfg_m), .i_ga_enable(i_ga_enable),
        .i_x_valid(i_x_valid), .i_x_data(i_x_data), .o_x_ready(o_x_ready),
        .i_ga_ready(i_ga_ready), .o_valid_pls(o_valid_pls),
        .o_v_vec_flat_n(o_v_vec_flat_n), .o_fill_cnt(o_fill_cnt), .o_vec_cnt(o_vec_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pls_cnt = 0;
    int consec = 0;
    logic prev_pls = 1'b0;
    logic [CHROM_MAX_W-1:0] last_vec = '0;
    logic [CHROM_MAX_W-1:0] exp_vec;
    int pls_before;
    logic got;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 2 ns after the rising edge, then inputs may be changed.
    task automatic cyc();
        @(posedge clk);
        #2;
        if (o_valid_pls === 1'b1) begin
            pls_cnt++;
            last_vec = o_v_vec_flat_n;
            if (prev_pls) consec++;
        end
        prev_pls = (o_valid_pls === 1'b1);
    endtask

    task automatic wait_pls(input int budget, output logic seen);
        int start;
        start = pls_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (pls_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        i_x_valid = 1'b1;
        i_x_data  = d;
        cyc();
        i_x_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_x_ready", o_x_ready, 0);
        check("rst_pls", o_valid_pls, 0);
        check("rst_vec", o_v_vec_flat_n, 0);
        check("rst_fill", o_fill_cnt, 0);
        check("rst_vec_cnt", o_vec_cnt, 0);

        // Fill with m=3: samples 1,2,3 back-to-back
        @(posedge clk); #2;
        rstn = 1'b1; cnfg_m = 6'd3; i_ga_enable = 1'b1; i_ga_ready = 1'b1;
        cyc();
        check("fill_x_ready", o_x_ready, 1);
        i_x_valid = 1'b1; i_x_data = 6'd1; cyc();
        i_x_data = 6'd2; cyc();
        i_x_data = 6'd3; cyc();
        i_x_valid = 1'b0;
        check("pend_x_ready", o_x_ready, 0);
        check("fill_cnt3", o_fill_cnt, 3);
        cyc();
        check("latency_no_pls_t1", o_valid_pls, 0);
        cyc();
        check("pls_t2", o_valid_pls, 1);
        check("fill_vec", o_v_vec_flat_n, 192'd4227);
        check("vec_cnt1", o_vec_cnt, 1);
        cyc();
        check("pls_one_cycle", o_valid_pls, 0);
        check("pls_cnt1", pls_cnt, 1);

        // Steady state: sample 4
        send(6'd4);
        check("run_pend_x_ready", o_x_ready, 0);
        wait_pls(6, got);
        check("steady_pls_seen", got, 1);
        check("steady_vec", last_vec, 192'd8388);
        check("vec_cnt2", o_vec_cnt, 2);

        // Back-pressure: sample 5 accepted, then 7 held for 5 cycles
        send(6'd5);
        i_ga_ready = 1'b0;
        i_x_valid = 1'b1; i_x_data = 6'd7;
        pls_before = pls_cnt;
        for (int i = 0; i < 5; i++) cyc();
        check("bp_no_pls", pls_cnt, pls_before);
        check("bp_x_ready", o_x_ready, 0);
        check("bp_fill", o_fill_cnt, 3);
        i_ga_ready = 1'b1;
        cyc();
        check("bp_pls", o_valid_pls, 1);
        check("bp_vec", o_v_vec_flat_n, 192'd12549);
        cyc();
        i_x_valid = 1'b0;
        check("bp_one_pls", pls_cnt, pls_before + 1);
        wait_pls(6, got);
        check("bp7_pls_seen", got, 1);
        check("bp7_vec", last_vec, 192'd16711);
        check("vec_cnt4", o_vec_cnt, 4);

        // Clamp m=0 -> m_eff=1
        i_ga_enable = 1'b0; cyc();
        check("dis_fill", o_fill_cnt, 0);
        check("dis_vec", o_v_vec_flat_n, 0);
        cnfg_m = 6'd0; i_ga_enable = 1'b1; cyc();
        send(6'h2A);
        wait_pls(6, got);
        check("m0_pls_seen", got, 1);
        check("m0_vec", last_vec, 192'h2A);
        check("m0_fill", o_fill_cnt, 1);
        send(6'h15);
        wait_pls(6, got);
        check("m0_pls2_seen", got, 1);
        check("m0_vec2", last_vec, 192'h15);

        // Clamp m=40 -> m_eff=32; later cnfg_m changes ignored
        i_ga_enable = 1'b0; cyc();
        cnfg_m = 6'd40; i_ga_enable = 1'b1; cyc();
        cnfg_m = 6'd5;
        pls_before = pls_cnt;
        i_x_valid = 1'b1;
        for (int i = 0; i < 31; i++) begin
            i_x_data = DATA_W'(i + 1);
            cyc();
        end
        check("m40_no_early_pls", pls_cnt, pls_before);
        check("m40_fill31", o_fill_cnt, 31);
        check("m40_still_ready", o_x_ready, 1);
        i_x_data = 6'd32; cyc();
        i_x_valid = 1'b0;
        wait_pls(6, got);
        check("m40_pls_seen", got, 1);
        check("m40_fill32", o_fill_cnt, 32);
        exp_vec = '0;
        for (int k = 0; k < 32; k++) exp_vec[k*DATA_W +: DATA_W] = DATA_W'(32 - k);
        check("m40_vec", last_vec, exp_vec);
        check("vec_cnt7", o_vec_cnt, 7);

        // Disable in PEND on the edge where the pulse would fire
        send(6'd9);
        cyc();
        pls_before = pls_cnt;
        i_ga_enable = 1'b0;
        cyc();
        check("dis_pend_pls", o_valid_pls, 0);
        check("dis_pend_vec", o_v_vec_flat_n, 0);
        check("dis_pend_fill", o_fill_cnt, 0);
        check("dis_pend_x_ready", o_x_ready, 0);
        cyc();
        check("dis_pend_no_pls", pls_cnt, pls_before);
        check("dis_vec_cnt_kept", o_vec_cnt, 7);

        // Async reset mid-FILL
        cnfg_m = 6'd3; i_ga_enable = 1'b1; cyc();
        send(6'd9);
        check("pre_rst_fill", o_fill_cnt, 1);
        #1 rstn = 1'b0;
        #1;
        check("arst_fill", o_fill_cnt, 0);
        check("arst_vec", o_v_vec_flat_n, 0);
        check("arst_x_ready", o_x_ready, 0);
        check("arst_vec_cnt", o_vec_cnt, 0);
        check("arst_pls", o_valid_pls, 0);
        cyc();
        rstn = 1'b1;
        cyc();
        check("post_rst_fill_ready", o_x_ready, 1);

        // Vector counter wrap
        force dut.r_vec_cnt = 16'hFFFF;
        #1 release dut.r_vec_cnt;
        send(6'd1); send(6'd2); send(6'd3);
        wait_pls(6, got);
        check("wrap_pls_seen", got, 1);
        check("wrap_vec_cnt", o_vec_cnt, 0);

        check("no_consecutive_pls", consec, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
